// File: rtl/ram_lsu_bridge_if.sv
//==============================================================================
// Module      : ram_lsu_bridge_if
// Description : Request/response handshake bundle between an LSU and the bridge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ram_lsu_bridge_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/ram_lsu_bridge.sv
//==============================================================================
// Module      : ram_lsu_bridge
// Description : Turns LSU byte/half/word requests into single-cycle RAM accesses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_lsu_bridge #(
    parameter int DP = 512,
    parameter int AW = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ram_lsu_bridge_if.slave  bus,
    output logic             ram_cs,
    output logic             ram_we,
    output logic [3:0]       ram_wem,
    output logic [AW-1:0]    ram_addr,
    output logic [31:0]      ram_din,
    input  wire logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic [1:0]  c_SZ_BYTE = 2'b00;
    localparam logic [1:0]  c_SZ_HALF = 2'b01;
    localparam logic [1:0]  c_SZ_WORD = 2'b10;
    localparam logic [1:0]  c_SZ_ILL  = 2'b11;
    localparam logic [AW:0] c_DEPTH   = (AW+1)'(DP);

    state_t        r_state;
    logic          r_req_ready;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_rsp_valid;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [AW-1:0] w_word_idx;
    logic          w_err;
    logic          w_access;
    logic [3:0]    w_wem;
    logic [31:0]   w_din;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    assign w_word_idx = r_addr >> 2;

    assign w_err = (r_size == c_SZ_ILL)
                 || ((r_size == c_SZ_HALF) && r_addr[0])
                 || ((r_size == c_SZ_WORD) && (r_addr[1:0] != 2'b00))
                 || ({1'b0, w_word_idx} >= c_DEPTH);

    // Only a clean request in ACC may touch the RAM.
    assign w_access = (r_state == S_ACC) && !w_err;

    always_comb begin
        w_wem = 4'b1111;
        w_din = r_wdata;
        case (r_size)
            c_SZ_BYTE: begin
                w_wem = 4'b0001 << r_addr[1:0];
                w_din = {4{r_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_wem = r_addr[1] ? 4'b1100 : 4'b0011;
                w_din = {2{r_wdata[15:0]}};
            end
            default: begin
                w_wem = 4'b1111;
                w_din = r_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = ram_dout[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (r_size)
            c_SZ_BYTE: w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = {{16{~r_uns & w_half[15]}}, w_half};
            default:   w_load = ram_dout;
        endcase
        if (r_we || w_err) begin
            w_load = 32'h0;
        end
    end

    assign ram_cs   = w_access;
    assign ram_we   = w_access && r_we;
    assign ram_wem  = (w_access && r_we) ? w_wem : 4'b0000;
    assign ram_addr = w_word_idx;
    assign ram_din  = w_din;

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_uns       <= bus.req_unsigned;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_rdata     <= w_load;
                    r_err       <= w_err;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
